// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 load, per-round C/D rotation, PC-2 output.
// Presents one 48-bit subkey per handshake, encrypt or decrypt order.
module des_key_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] key,
   input  logic        decrypt,
   input  logic        next_key,
   output logic        subkey_valid,
   output logic [47:0] pc2subkey,
   output logic [3:0]  round_idx,
   output logic        busy,
   output logic        done
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   // DES bit numbers, 1 = MSB
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   logic [0:0]  state;
   logic [27:0] c;
   logic [27:0] d;
   logic [3:0]  cnt;
   logic        dec;
   logic [55:0] cd0;
   logic [55:0] cd;
   logic        last;
   logic        parity_unused;

   // Parity bits of the key carry no key material.
   assign parity_unused = ^{key[56], key[48], key[40], key[32],
                            key[24], key[16], key[8],  key[0]};

   genvar gi;
   generate
      for (gi = 0; gi < 56; gi++) begin : g_pc1
         assign cd0[55-gi] = key[64-PC1[gi]];
      end
   endgenerate

   assign cd = {c, d};

   generate
      for (gi = 0; gi < 48; gi++) begin : g_pc2
         assign pc2subkey[47-gi] = cd[56-PC2[gi]];
      end
   endgenerate

   function automatic logic two_shift(input logic [3:0] r);
      return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] x,
                                        input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x,
                                        input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   assign last         = dec ? (cnt == 4'd0) : (cnt == 4'd15);
   assign subkey_valid = (state == ACTIVE);
   assign busy         = (state == ACTIVE);
   assign round_idx    = cnt;

   // Load on start, then step C/D one round per accepted subkey.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         c     <= '0;
         d     <= '0;
         cnt   <= '0;
         dec   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= ACTIVE;
                  dec   <= decrypt;
                  if (decrypt) begin
                     c   <= cd0[55:28];
                     d   <= cd0[27:0];
                     cnt <= 4'd15;
                  end else begin
                     c   <= rotl(cd0[55:28], 1'b0);
                     d   <= rotl(cd0[27:0], 1'b0);
                     cnt <= 4'd0;
                  end
               end
            end
            ACTIVE: begin
               if (next_key) begin
                  if (last) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else if (dec) begin
                     c   <= rotr(c, two_shift(cnt));
                     d   <= rotr(d, two_shift(cnt));
                     cnt <= cnt - 4'd1;
                  end else begin
                     c   <= rotl(c, two_shift(cnt + 4'd1));
                     d   <= rotl(d, two_shift(cnt + 4'd1));
                     cnt <= cnt + 4'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: sequence-level model plus
// known-answer vectors for encrypt, decrypt, stalls and reset.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] key;
   logic        decrypt;
   logic        next_key;
   logic        subkey_valid;
   logic [47:0] pc2subkey;
   logic [3:0]  round_idx;
   logic        busy;
   logic        done;

   int errors = 0;
   int checks = 0;

   des_key_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .key          (key),
      .decrypt      (decrypt),
      .next_key     (next_key),
      .subkey_valid (subkey_valid),
      .pc2subkey    (pc2subkey),
      .round_idx    (round_idx),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   localparam int T_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int T_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2,
                                1, 2, 2, 2, 2, 2, 2, 1};

   localparam logic [63:0] KEY1 = 64'h133457799BBCDFF1;
   localparam logic [47:0] K1   = 48'h1B02EFFC7072;
   localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

   // Subkey r (0-based) straight from the definition:
   // C_r = C0 rotated left by the cumulative shift count.
   function automatic logic [47:0] sk(input logic [63:0] k, input int r);
      logic [55:0] cd;
      logic [27:0] c;
      logic [27:0] d;
      logic [47:0] o;
      int n;
      cd = '0;
      for (int i = 0; i < 56; i++)
         cd = {cd[54:0], 1'(k >> (64 - T_PC1[i]))};
      n = 0;
      for (int i = 0; i <= r; i++) n += T_SH[i];
      n = n % 28;
      c = cd[55:28];
      d = cd[27:0];
      if (n != 0) begin
         c = 28'((c << n) | (c >> (28 - n)));
         d = 28'((d << n) | (d >> (28 - n)));
      end
      cd = {c, d};
      o = '0;
      for (int i = 0; i < 48; i++)
         o = {o[46:0], 1'(cd >> (56 - T_PC2[i]))};
      return o;
   endfunction

   // Sequence model: position within the 16-subkey list.
   logic        m_active;
   logic        m_done;
   logic        m_dec;
   logic [63:0] m_key;
   int          m_pos;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_pos    <= 0;
         m_dec    <= 1'b0;
         m_key    <= '0;
      end else begin
         m_done <= 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active <= 1'b1;
               m_pos    <= 0;
               m_key    <= key;
               m_dec    <= decrypt;
            end
         end else if (next_key) begin
            if (m_pos == 15) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
            end else begin
               m_pos <= m_pos + 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic cmp();
      int idx;
      chk("valid", 64'(subkey_valid), 64'(m_active));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      if (m_active) begin
         idx = m_dec ? 15 - m_pos : m_pos;
         chk("round_idx", 64'(round_idx), 64'(idx));
         chk("subkey", 64'(pc2subkey), 64'(sk(m_key, idx)));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      cmp();
   endtask

   task automatic wait_done(input string nm);
      int c;
      c = 0;
      while (!done && c < 100) begin
         tick();
         c++;
      end
      chk(nm, 64'(done), 64'd1);
   endtask

   logic [47:0] enc [16];
   logic [47:0] dsq [16];
   logic [63:0] wk  [3];
   logic [47:0] wx  [3];
   logic        seen;

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      key      = '0;
      decrypt  = 1'b0;
      next_key = 1'b0;

      #1;
      chk("rst_valid", 64'(subkey_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_subkey", 64'(pc2subkey), 64'd0);
      chk("rst_idx", 64'(round_idx), 64'd0);

      chk("model_k1", 64'(sk(KEY1, 0)), 64'(K1));
      chk("model_k16", 64'(sk(KEY1, 15)), 64'(K16));

      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Encrypt, no stalls
      key = KEY1; decrypt = 1'b0; start = 1'b1; next_key = 1'b1;
      tick();
      start = 1'b0;
      chk("enc_first", 64'(pc2subkey), 64'(K1));
      chk("enc_first_idx", 64'(round_idx), 64'd0);
      enc[0] = pc2subkey;
      for (int i = 1; i < 16; i++) begin
         tick();
         enc[i] = pc2subkey;
      end
      chk("enc_last", 64'(pc2subkey), 64'(K16));
      chk("enc_last_idx", 64'(round_idx), 64'd15);
      tick();
      chk("enc_done_16", 64'(done), 64'd1);
      chk("enc_done_busy", 64'(busy), 64'd0);
      tick();

      // Decrypt, no stalls
      key = KEY1; decrypt = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("dec_first", 64'(pc2subkey), 64'(K16));
      chk("dec_first_idx", 64'(round_idx), 64'd15);
      dsq[0] = pc2subkey;
      for (int i = 1; i < 16; i++) begin
         tick();
         dsq[i] = pc2subkey;
      end
      chk("dec_last", 64'(pc2subkey), 64'(K1));
      chk("dec_last_idx", 64'(round_idx), 64'd0);
      for (int i = 0; i < 16; i++)
         chk("dec_reverse", 64'(dsq[i]), 64'(enc[15-i]));
      tick();
      chk("dec_done", 64'(done), 64'd1);
      tick();

      // Degenerate keys
      wk[0] = 64'h0000000000000000; wx[0] = 48'h000000000000;
      wk[1] = 64'h0101010101010101; wx[1] = 48'h000000000000;
      wk[2] = 64'hFEFEFEFEFEFEFEFE; wx[2] = 48'hFFFFFFFFFFFF;
      for (int w = 0; w < 3; w++) begin
         chk("model_weak", 64'(sk(wk[w], 5)), 64'(wx[w]));
         key = wk[w]; decrypt = 1'b0; start = 1'b1;
         tick();
         start = 1'b0;
         for (int i = 0; i < 16; i++) begin
            chk("weak_subkey", 64'(pc2subkey), 64'(wx[w]));
            tick();
         end
         chk("weak_done", 64'(done), 64'd1);
         tick();
      end

      // Random stalls with ignored start pulses
      key = 64'h0E329232EA6D0D73; decrypt = 1'b0; start = 1'b1;
      next_key = 1'b0;
      tick();
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         next_key = 1'($urandom_range(0, 1));
         start = (c % 7 == 3);
         key = 64'hFFFF0000FFFF0000 ^ 64'(c);
         decrypt = 1'(c);
         tick();
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk("stall_done", 64'(seen), 64'd1);
      tick();

      // Asynchronous reset mid-schedule
      key = KEY1; decrypt = 1'b0; start = 1'b1; next_key = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40 && round_idx != 4'd7; c++) tick();
      chk("reach_idx7", 64'(round_idx), 64'd7);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(subkey_valid), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_subkey", 64'(pc2subkey), 64'd0);
      chk("arst_idx", 64'(round_idx), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("arst_no_done", 64'(seen), 64'd0);
      key = KEY1; decrypt = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("arst_restart_k1", 64'(pc2subkey), 64'(K1));

      // Start accepted in the done cycle
      wait_done("b2b_done");
      key = KEY1; decrypt = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_valid", 64'(subkey_valid), 64'd1);
      chk("b2b_idx", 64'(round_idx), 64'd15);
      chk("b2b_first", 64'(pc2subkey), 64'(K16));
      wait_done("b2b_final_done");
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator that produces the 48-bit round subkeys consumed by the f-function stage on its `pc2subkey` input. It applies PC-1 to a 64-bit key on `start` and holds the 28-bit C/D halves in registers. It then steps through the 16 rounds, rotating C/D and presenting PC-2(C,D) one round at a time under a valid/next handshake driven by the downstream round engine. Encrypt order (K1..K16) and decrypt order (K16..K1) are both supported.

## Interface
- No parameters; all widths are fixed by DES.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a new schedule; sampled only in IDLE.
- `key`  in  64  DES key; `key[63]` is DES bit 1; parity bits 8,16,…,64 ignored; sampled on accepted `start`.
- `decrypt`  in  1  0 = emit K1..K16, 1 = emit K16..K1; sampled on accepted `start`.
- `next_key`  in  1  consumer accepts the current subkey.
- `subkey_valid`  out  1  `pc2subkey` holds a valid subkey.
- `pc2subkey`  out  48  PC-2(C,D) of the current round; `[47]` is subkey bit 1.
- `round_idx`  out  4  DES round number minus 1 (0 = K1 … 15 = K16) of the presented subkey.
- `busy`  out  1  high in ACTIVE.
- `done`  out  1  one-cycle pulse after the final subkey is accepted.

## Operation
- Shift schedule for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Registers: C[27:0], D[27:0], a 4-bit step counter, a latched `decrypt` flag, and the FSM state.
- States are IDLE and ACTIVE.
- IDLE, `start`=1:
  - Compute {C0,D0} = PC-1(key).
  - Encrypt: load C,D ← C0,D0 rotated left by 1; `round_idx` = 0.
  - Decrypt: load C,D ← C0,D0 unrotated (C16 = C0); `round_idx` = 15.
  - Next state is ACTIVE.
- IDLE ignores `next_key`.
- ACTIVE: `subkey_valid` = 1. `pc2subkey` is combinational PC-2 of the C/D registers only; it has no path from inputs.
- ACTIVE, `next_key`=1 with rounds remaining:
  - Encrypt: `round_idx` += 1; rotate C and D left by shift[new round].
  - Decrypt: rotate C and D right by shift[current round]; `round_idx` −= 1.
- ACTIVE, `next_key`=1 on the last subkey (encrypt `round_idx`=15, decrypt `round_idx`=0): next state IDLE, `done` = 1 for the next cycle.
- ACTIVE, `next_key`=0: hold all state; the subkey stays stable.
- `start` during ACTIVE is ignored. `key` and `decrypt` changes after load have no effect.
- C and D rotate independently as 28-bit fields; no bits cross between halves.
- After 16 encrypt steps the cumulative shift is 28, so C,D return to C0,D0.

## Timing
- Reset values: state IDLE; C, D, counter, `round_idx` = 0; `subkey_valid`, `busy`, `done` = 0.
- Because C,D reset to 0, `pc2subkey` = 0 while in reset.
- Latency: `start` accepted at edge N gives `subkey_valid`=1 with the first subkey from edge N+1.
- Throughput: one subkey per cycle when `next_key` is held high. A full schedule is 16 cycles from first valid to last accept.
- `done` is asserted in the cycle after the last accept, with `subkey_valid`=0 and `busy`=0.
- A `start` in that `done` cycle is accepted; back-to-back schedules are legal.
- `rst_n` low at any point, mid-schedule included, returns all state to reset values immediately and asynchronously. No `done` is emitted.
- `next_key` while `subkey_valid`=0 has no effect.
- `start` and `next_key` both high in IDLE: only `start` acts.

## Test plan
- Key 133457799BBCDFF1, encrypt, `next_key` held high → K1 = 1B02EFFC7072 one cycle after `start`, and K16 = CB3D8B0E17F5 at `round_idx`=15. `done` pulses exactly 16 cycles after the first valid.
- Same key, decrypt → first subkey CB3D8B0E17F5 with `round_idx`=15, last subkey 1B02EFFC7072 with `round_idx`=0. The full 16-subkey sequence equals the encrypt sequence reversed.
- Keys 0000000000000000 and 0101010101010101 → all 16 subkeys 000000000000. Key FEFEFEFEFEFEFEFE → all 16 subkeys FFFFFFFFFFFF.
- Random stalls on `next_key` → `pc2subkey` and `round_idx` are stable during stalls, and no round is skipped or repeated. `start` pulsed mid-schedule → ignored.
- `rst_n` driven low at `round_idx`=7, asynchronously between clock edges → outputs go to reset values without waiting for a clock edge, and no `done` is emitted. A subsequent `start` with key 133457799BBCDFF1 yields 1B02EFFC7072 first.
- `start` asserted in the `done` cycle with `decrypt`=1 → a new schedule starts and the first subkey is valid the next cycle.
